// File: rtl/divider_controller.sv
// Programmable clock divider with IDLE/RUN/STOPPING control and glitch-free ratio updates.
// Optional Periods output when DIVIDER_CONTROLLER_PERIOD_COUNT_EN is defined.
module divider_controller #(
    parameter int N           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Enable,
    input  logic [N-1:0] Div,
    input  logic         DivValid,
    output logic         DivReady,
    output logic [N-1:0] Count,
    output logic         ClkOut,
    output logic         Tick,
    output logic         Busy
`ifdef DIVIDER_CONTROLLER_PERIOD_COUNT_EN
    ,
    output logic [15:0]  Periods
`endif
);

    localparam logic [1:0]   ST_IDLE = 2'd0;
    localparam logic [1:0]   ST_RUN  = 2'd1;
    localparam logic [1:0]   ST_STOP = 2'd2;
    localparam logic [N-1:0] ONE     = N'(1);
    localparam logic [N-1:0] DIV_MIN = N'(2);
    localparam logic [N-1:0] DIV_RST = N'(DEFAULT_DIV);

    logic [1:0]   state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] div_q, div_d;
    logic [N-1:0] pend_q, pend_d;
    logic         pend_full_q, pend_full_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         running, accept, wrap;
    logic [N-1:0] div_in;
    logic [N:0]   half;

    always_comb begin
        running     = (state_q != ST_IDLE);
        accept      = DivValid && !pend_full_q;
        div_in      = (Div < DIV_MIN) ? DIV_MIN : Div;
        wrap        = running && (count_q == div_q - ONE);
        state_d     = state_q;
        count_d     = count_q;
        div_d       = div_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (accept) div_d = div_in;
                if (Enable) state_d = ST_RUN;
            end
            default: begin
                // The active ratio only ever changes on a wrap edge, so no period is cut short.
                if (wrap) begin
                    count_d = '0;
                    if (pend_full_q) begin
                        div_d       = pend_q;
                        pend_full_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
                if (accept) begin
                    pend_d      = div_in;
                    pend_full_d = 1'b1;
                end
                if (Enable)                            state_d = ST_RUN;
                else if (state_q == ST_STOP && wrap)   state_d = ST_IDLE;
                else                                   state_d = ST_STOP;
                // Nothing may stay pending once stopped; promote whatever is held.
                if (state_d == ST_IDLE) begin
                    pend_full_d = 1'b0;
                    if (accept) div_d = div_in;
                end
            end
        endcase

        // Outputs are registered from next-state values; half is one bit wider so D=2^N-1 cannot overflow.
        half      = ({1'b0, div_d} + (N+1)'(1)) >> 1;
        clk_out_d = (state_d != ST_IDLE) && ({1'b0, count_d} < half);
        tick_d    = (state_d != ST_IDLE) && (count_d == div_d - ONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            div_q       <= DIV_RST;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    assign DivReady = !pend_full_q;
    assign Count    = count_q;
    assign ClkOut   = clk_out_q;
    assign Tick     = tick_q;
    assign Busy     = running;

`ifdef DIVIDER_CONTROLLER_PERIOD_COUNT_EN
    logic [15:0] periods_q, periods_d;

    always_comb begin
        periods_d = periods_q;
        if (state_q == ST_IDLE && state_d == ST_RUN)
            periods_d = '0;
        else if (wrap && periods_q != 16'hFFFF)
            periods_d = periods_q + 16'd1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) periods_q <= '0;
        else       periods_q <= periods_d;
    end

    assign Periods = periods_q;
`endif

endmodule

// File: tb/tb_divider_controller.sv
// Scoreboard bench for divider_controller: a behavioural model predicts each cycle, a monitor compares.
module tb_divider_controller;

    localparam int N   = 8;
    localparam int DEF = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         dv  = 1'b0;
    logic [N-1:0] d   = '0;
    logic         rdy, co, tk, busy;
    logic [N-1:0] cnt;
`ifdef DIVIDER_CONTROLLER_PERIOD_COUNT_EN
    logic [15:0]  per;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divider_controller #(.N(N), .DEFAULT_DIV(DEF)) dut (
        .Clk      (clk),
        .Reset    (rst),
        .Enable   (en),
        .Div      (d),
        .DivValid (dv),
        .DivReady (rdy),
        .Count    (cnt),
        .ClkOut   (co),
        .Tick     (tk),
        .Busy     (busy)
`ifdef DIVIDER_CONTROLLER_PERIOD_COUNT_EN
        ,
        .Periods  (per)
`endif
    );

    typedef enum {M_IDLE, M_RUN, M_STOP} mode_e;
    typedef struct {
        int cnt;
        bit co;
        bit tk;
        bit busy;
        bit rdy;
        int per;
    } exp_t;

    exp_t  sb[$];
    mode_e m_mode      = M_IDLE;
    int    m_cnt       = 0;
    int    m_ratio     = DEF;
    int    m_pend      = 0;
    int    m_per       = 0;
    bit    m_pend_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the reference model by one clock edge and queue the outputs it predicts.
    task automatic model_step(input bit r, input bit e, input bit v, input int dval);
        exp_t x;
        bit   acc;
        bit   at_wrap;
        int   dn;
        if (r) begin
            m_mode = M_IDLE; m_cnt = 0; m_ratio = DEF; m_pend_full = 1'b0; m_per = 0;
        end else begin
            acc = v && !m_pend_full;
            dn  = (dval < 2) ? 2 : dval;
            if (m_mode == M_IDLE) begin
                if (acc) m_ratio = dn;
                if (e) begin m_mode = M_RUN; m_cnt = 0; m_per = 0; end
            end else begin
                at_wrap = (m_cnt == m_ratio - 1);
                if (at_wrap) begin
                    m_cnt = 0;
                    if (m_per < 65535) m_per++;
                    if (m_pend_full) begin m_ratio = m_pend; m_pend_full = 1'b0; end
                end else begin
                    m_cnt++;
                end
                if (acc) begin m_pend = dn; m_pend_full = 1'b1; end
                if (e)                             m_mode = M_RUN;
                else if (m_mode == M_STOP && at_wrap) m_mode = M_IDLE;
                else                               m_mode = M_STOP;
                if (m_mode == M_IDLE && m_pend_full) begin
                    m_ratio = m_pend; m_pend_full = 1'b0;
                end
            end
        end
        x.busy = (m_mode != M_IDLE);
        x.cnt  = m_cnt;
        x.co   = x.busy && (m_cnt < (m_ratio + 1) / 2);
        x.tk   = x.busy && (m_cnt == m_ratio - 1);
        x.rdy  = !m_pend_full;
        x.per  = m_per;
        sb.push_back(x);
    endtask

    task automatic cyc(input bit r, input bit e, input bit v, input int dval);
        logic [31:0] dv32;
        @(negedge clk);
        dv32 = dval;
        rst  = r; en = e; dv = v; d = dv32[N-1:0];
        model_step(r, e, v, dval);
        @(posedge clk);
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    task automatic wait_cnt(input int c);
        int n = 0;
        while (m_cnt != c && n < 600) begin cyc(0, 1, 0, 0); n++; end
        if (n >= 600) timeout("wait_cnt");
    endtask

    task automatic go_idle();
        int n = 0;
        while (m_mode != M_IDLE && n < 600) begin cyc(0, 0, 0, 0); n++; end
        if (n >= 600) timeout("go_idle");
    endtask

    // Monitor: compare the DUT against the oldest prediction just after each edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("count",     32'(cnt),  32'(x.cnt));
            check("clk_out",   32'(co),   32'(x.co));
            check("tick",      32'(tk),   32'(x.tk));
            check("busy",      32'(busy), 32'(x.busy));
            check("div_ready", 32'(rdy),  32'(x.rdy));
`ifdef DIVIDER_CONTROLLER_PERIOD_COUNT_EN
            check("periods",   32'(per),  32'(x.per));
`endif
        end
    end

    initial begin
        bit r, e, v;
        int dval;

        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 9);                   // inputs ignored while in reset
        repeat (12) cyc(0, 1, 0, 0);       // default ratio 4

        go_idle();
        cyc(0, 0, 1, 5);                   // ratio 5 loaded in idle
        repeat (15) cyc(0, 1, 0, 0);

        go_idle();
        cyc(0, 0, 1, 4);
        cyc(0, 1, 0, 0);
        wait_cnt(1);
        cyc(0, 1, 1, 6);                   // accepted as pending
        repeat (14) cyc(0, 1, 1, 7);       // held until the register frees up
        repeat (20) cyc(0, 1, 0, 0);

        go_idle();
        cyc(0, 0, 1, 4);
        cyc(0, 1, 0, 0);
        wait_cnt(1);
        go_idle();                         // stop requested at count 1
        cyc(0, 1, 0, 0);
        wait_cnt(1);
        cyc(0, 0, 0, 0);                   // stopping, count goes to 2
        repeat (8) cyc(0, 1, 0, 0);        // resumed without a gap

        go_idle();
        cyc(0, 0, 1, 0);
        repeat (6) cyc(0, 1, 0, 0);
        go_idle();
        cyc(0, 0, 1, 1);
        repeat (6) cyc(0, 1, 0, 0);
        go_idle();
        cyc(0, 0, 1, 255);                 // widest ratio wraps 254 -> 0
        repeat (260) cyc(0, 1, 0, 0);

        go_idle();
        cyc(0, 0, 1, 4);
        cyc(0, 1, 0, 0);
        wait_cnt(1);
        cyc(0, 1, 1, 9);                   // pending ratio, count becomes 2
        cyc(1, 1, 0, 0);                   // reset discards it
        repeat (10) cyc(0, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            e    = ($urandom_range(0, 9) != 0);
            v    = ($urandom_range(0, 7) == 0);
            dval = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 9));
            cyc(r, e, v, dval);
        end

        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
